// File: rtl/imm_gen_q.sv
// imm_gen_q: registered RV32I/RV64I immediate generator with a DEPTH-entry output FIFO.
// Decodes every immediate format (I, SHAMT, S, B, U, J) of an incoming instruction,
// sign-extends it to XLEN and queues it with a format code and an illegal flag.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   flush              synchronous clear of all buffered entries (drops same-cycle push/pop)
//   in_valid/in_ready  instruction handshake; inst is the 32-bit instruction word
//   out_valid/out_ready head handshake
//   out_imm            decoded immediate at the head (0 when empty)
//   out_fmt            0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT (0 when empty)
//   out_illegal        head opcode carries no immediate (0 when empty)
//   count              current occupancy
module imm_gen_q #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [CW-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec_c;
  entry_t          head_c;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   cnt;
  logic            push_c;
  logic            pop_c;

  // Immediate decode; signed casts replicate inst[31] up to XLEN-1.
  always_comb begin
    dec_c = '0;
    unique case (inst[6:0])
      OP_LOAD, OP_JALR: begin
        dec_c.imm = XLEN'($signed(inst[31:20]));
        dec_c.fmt = FMT_I;
      end
      OP_IMM: begin
        if (inst[13:12] == 2'b01) begin
          // funct3 001/101 are shifts: shamt is 5 bits on RV32, 6 bits on RV64
          dec_c.fmt = FMT_SHAMT;
          if (XLEN == 64) dec_c.imm = XLEN'(inst[25:20]);
          else            dec_c.imm = XLEN'(inst[24:20]);
        end else begin
          dec_c.imm = XLEN'($signed(inst[31:20]));
          dec_c.fmt = FMT_I;
        end
      end
      OP_STORE: begin
        dec_c.imm = XLEN'($signed({inst[31:25], inst[11:7]}));
        dec_c.fmt = FMT_S;
      end
      OP_BRANCH: begin
        dec_c.imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        dec_c.fmt = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        dec_c.imm = XLEN'($signed({inst[31:12], 12'b0}));
        dec_c.fmt = FMT_U;
      end
      OP_JAL: begin
        dec_c.imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        dec_c.fmt = FMT_J;
      end
      default: begin
        dec_c.fmt     = FMT_NONE;
        dec_c.illegal = 1'b1;
      end
    endcase
  end

  // Handshake qualification; flush drops both sides of the transfer.
  assign in_ready  = (cnt != CW'(DEPTH)) && !rst;
  assign out_valid = (cnt != '0);
  assign push_c    = in_valid && in_ready && !flush;
  assign pop_c     = out_valid && out_ready && !flush;

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_c) wptr <= wptr + PW'(1);
      if (pop_c)  rptr <= rptr + PW'(1);
      if (push_c && !pop_c)      cnt <= cnt + CW'(1);
      else if (pop_c && !push_c) cnt <= cnt - CW'(1);
    end
  end

  // Entry storage; contents need no reset since occupancy gates the head.
  always_ff @(posedge clk) begin
    if (push_c) mem[wptr] <= dec_c;
  end

  // Head is forced to zero when empty.
  assign head_c      = out_valid ? mem[rptr] : '0;
  assign out_imm     = head_c.imm;
  assign out_fmt     = head_c.fmt;
  assign out_illegal = head_c.illegal;
  assign count       = cnt;

endmodule

// File: tb/tb_imm_gen_q.sv
// Testbench for imm_gen_q: an XLEN=32/DEPTH=2 and an XLEN=64/DEPTH=4 instance checked
// each cycle against an arithmetic immediate model and a queue-based FIFO model.
module tb_imm_gen_q;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fl   [2];
  logic        iv   [2];
  logic        ordy [2];
  logic [31:0] ins  [2];

  logic        ir0, ov0, il0;
  logic [31:0] oi0;
  logic [2:0]  of0;
  logic [1:0]  cnt0;

  logic        ir1, ov1, il1;
  logic [63:0] oi1;
  logic [2:0]  of1;
  logic [2:0]  cnt1;

  imm_gen_q #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir0),
    .inst(ins[0]), .out_valid(ov0), .out_ready(ordy[0]), .out_imm(oi0),
    .out_fmt(of0), .out_illegal(il0), .count(cnt0)
  );

  imm_gen_q #(.XLEN(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir1),
    .inst(ins[1]), .out_valid(ov1), .out_ready(ordy[1]), .out_imm(oi1),
    .out_fmt(of1), .out_illegal(il1), .count(cnt1)
  );

  typedef struct {
    logic [63:0] imm;
    int          fmt;
    bit          ill;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Immediate value built from field weights rather than bit concatenation.
  function automatic ent_t ref_dec(input logic [31:0] i, input int xlen);
    ent_t   e;
    longint s;
    longint sgn;
    s     = 0;
    e.fmt = 0;
    e.ill = 1'b0;
    case (i[6:0])
      7'h03, 7'h67: begin s = longint'($signed(i)) >>> 20; e.fmt = 1; end
      7'h13: begin
        if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
          s     = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
          e.fmt = 6;
        end else begin
          s     = longint'($signed(i)) >>> 20;
          e.fmt = 1;
        end
      end
      7'h23: begin s = (longint'($signed(i)) >>> 25) * 32 + longint'(i[11:7]); e.fmt = 2; end
      7'h63: begin
        sgn   = i[31] ? -64'sd4096 : 64'sd0;
        s     = sgn + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        e.fmt = 3;
      end
      7'h37, 7'h17: begin s = longint'($signed(i & 32'hFFFF_F000)); e.fmt = 4; end
      7'h6F: begin
        sgn   = i[31] ? -64'sd1048576 : 64'sd0;
        s     = sgn + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        e.fmt = 5;
      end
      default: e.ill = 1'b1;
    endcase
    e.imm = (xlen == 32) ? (64'(s) & 64'hFFFF_FFFF) : 64'(s);
    return e;
  endfunction

  task automatic check_all();
    ent_t z;
    int   n;
    z = '{imm: 64'd0, fmt: 0, ill: 1'b0};
    n = q0.size();
    chk("d32_count", 64'(cnt0), 64'(n));
    chk("d32_out_valid", 64'(ov0), 64'(n != 0));
    chk("d32_in_ready", 64'(ir0), 64'((n < 2) && !rst));
    chk("d32_out_imm", 64'(oi0), (n != 0) ? q0[0].imm : z.imm);
    chk("d32_out_fmt", 64'(of0), (n != 0) ? 64'(q0[0].fmt) : 64'd0);
    chk("d32_out_illegal", 64'(il0), (n != 0) ? 64'(q0[0].ill) : 64'd0);
    n = q1.size();
    chk("d64_count", 64'(cnt1), 64'(n));
    chk("d64_out_valid", 64'(ov1), 64'(n != 0));
    chk("d64_in_ready", 64'(ir1), 64'((n < 4) && !rst));
    chk("d64_out_imm", oi1, (n != 0) ? q1[0].imm : z.imm);
    chk("d64_out_fmt", 64'(of1), (n != 0) ? 64'(q1[0].fmt) : 64'd0);
    chk("d64_out_illegal", 64'(il1), (n != 0) ? 64'(q1[0].ill) : 64'd0);
  endtask

  // One clock: drive instance sel (other idles), check state, advance the model.
  task automatic cyc(input int sel, input bit v, input logic [31:0] i, input bit r, input bit f);
    bit push0, pop0, push1, pop1;
    for (int s = 0; s < 2; s++) begin
      iv[s]   = (s == sel) ? v : 1'b0;
      ins[s]  = (s == sel) ? i : 32'd0;
      ordy[s] = (s == sel) ? r : 1'b0;
      fl[s]   = (s == sel) ? f : 1'b0;
    end
    #1;
    check_all();
    push0 = iv[0] && q0.size() < 2 && !rst && !fl[0];
    pop0  = ordy[0] && q0.size() > 0 && !rst && !fl[0];
    push1 = iv[1] && q1.size() < 4 && !rst && !fl[1];
    pop1  = ordy[1] && q1.size() > 0 && !rst && !fl[1];
    @(posedge clk);
    if (rst || fl[0]) q0.delete();
    else begin
      if (pop0)  void'(q0.pop_front());
      if (push0) q0.push_back(ref_dec(ins[0], 32));
    end
    if (rst || fl[1]) q1.delete();
    else begin
      if (pop1)  void'(q1.pop_front());
      if (push1) q1.push_back(ref_dec(ins[1], 64));
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    logic [6:0]  ops [10];
    ops = '{7'h03, 7'h67, 7'h13, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    x = $urandom;
    x[6:0] = ops[$urandom_range(0, 9)];
    return x;
  endfunction

  logic [31:0] strm_inst [6];
  logic [31:0] strm_imm  [6];
  logic [2:0]  strm_fmt  [6];

  initial begin
    strm_inst = '{32'h0051_2423, 32'hFE00_0CE3, 32'h1234_50B7, 32'h0010_00EF, 32'h01F0_D093, 32'h0000_007F};
    strm_imm  = '{32'h0000_0008, 32'hFFFF_FFF8, 32'h1234_5000, 32'h0000_0800, 32'h0000_001F, 32'h0000_0000};
    strm_fmt  = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; ordy[s] = 1'b0; fl[s] = 1'b0; ins[s] = 32'd0;
    end
    repeat (2) @(negedge clk);
    cyc(-1, 0, 32'd0, 0, 0);
    rst = 1'b0;

    // First transaction: one-cycle latency to the head.
    cyc(0, 1, 32'hFFC1_2083, 0, 0);
    chk("lw_imm", 64'(oi0), 64'hFFFF_FFFC);
    chk("lw_fmt", 64'(of0), 64'd1);
    chk("lw_count", 64'(cnt0), 64'd1);

    // Streaming with out_ready=1: one head per cycle, count holds at 1.
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, strm_inst[k], 1, 0);
      chk("stream_imm", 64'(oi0), 64'(strm_imm[k]));
      chk("stream_fmt", 64'(of0), 64'(strm_fmt[k]));
      chk("stream_count", 64'(cnt0), 64'd1);
    end
    chk("stream_illegal", 64'(il0), 64'd1);
    cyc(0, 0, 32'd0, 1, 0);

    // Stall: fill, third offer ignored, one-cycle pop pulse.
    cyc(0, 1, 32'h0051_2423, 0, 0);
    cyc(0, 1, 32'hFE00_0CE3, 0, 0);
    chk("full_count", 64'(cnt0), 64'd2);
    chk("full_in_ready", 64'(ir0), 64'd0);
    cyc(0, 1, 32'h1234_50B7, 0, 0);
    chk("stall_head", 64'(oi0), 64'h0000_0008);
    cyc(0, 1, 32'h1234_50B7, 1, 0);
    chk("pulse_count", 64'(cnt0), 64'd1);
    chk("pulse_in_ready", 64'(ir0), 64'd1);
    chk("pulse_head", 64'(oi0), 64'hFFFF_FFF8);
    cyc(0, 0, 32'd0, 1, 0);

    // Flush with a same-cycle offer: everything dropped.
    cyc(0, 1, 32'hFFC1_2083, 0, 0);
    cyc(0, 1, 32'h0051_2423, 0, 0);
    cyc(0, 1, 32'h1234_50B7, 1, 1);
    chk("flush_count", 64'(cnt0), 64'd0);
    chk("flush_imm", 64'(oi0), 64'd0);
    cyc(0, 0, 32'd0, 0, 0);
    chk("flush_absent", 64'(ov0), 64'd0);

    // XLEN=64 instance.
    cyc(1, 1, 32'hFE00_0CE3, 0, 0);
    chk("x64_beq", oi1, 64'hFFFF_FFFF_FFFF_FFF8);
    cyc(1, 1, 32'h03F0_D093, 1, 0);
    chk("x64_shamt", oi1, 64'h0000_0000_0000_003F);
    chk("x64_shamt_fmt", 64'(of1), 64'd6);
    for (int k = 0; k < 40; k++)
      cyc(1, ($urandom_range(0, 3) != 0), rand_inst(), ($urandom_range(0, 1) == 1), 0);
    for (int k = 0; k < 6; k++) cyc(1, 0, 32'd0, 1, 0);

    // Random stream on the DEPTH=2 instance, reset mid-stream.
    for (int k = 0; k < 60; k++) begin
      if (k == 40) rst = 1'b1;
      cyc(0, ($urandom_range(0, 3) != 0), rand_inst(), ($urandom_range(0, 1) == 1), 0);
      if (k == 40) begin
        rst = 1'b0;
        chk("midrst_count", 64'(cnt0), 64'd0);
        chk("midrst_valid", 64'(ov0), 64'd0);
        chk("midrst_imm", 64'(oi0), 64'd0);
        chk("midrst_fmt", 64'(of0), 64'd0);
      end
    end
    for (int k = 0; k < 4; k++) cyc(0, 0, 32'd0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_q.md
Name: imm_gen_q

Overview:
- Parametrised, registered successor to the combinational immediate generator in the multicycle RISC-V datapath.
- Accepts 32-bit instructions over a valid/ready handshake and decodes every RV32I/RV64I immediate format (I, shift-amount, S, B, U, J), sign-extended to XLEN.
- Buffers results in a DEPTH-entry FIFO together with a format code and an illegal flag.
- Sits between the instruction register and the ALU-source mux / branch-target adder.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- DEPTH, 2, FIFO entries; power of two, 2..16.
- CW, $clog2(DEPTH+1), occupancy counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous clear of all buffered entries.
- in_valid  input  1  instruction offered.
- in_ready  output  1  block can accept an instruction this cycle.
- inst  input  32  instruction word.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer takes the head this cycle.
- out_imm  output  XLEN  decoded immediate at the head.
- out_fmt  output  3  format at the head: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- out_illegal  output  1  head opcode carries no immediate or is unrecognised.
- count  output  CW  current occupancy.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: count=0, out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, and read/write pointers=0. rst asserted mid-operation discards all entries on that edge.
- Decode is combinational on inst and is written into the FIFO on push.
- Opcodes 0000011 (load), 1100111 (jalr), and 0010011 (op-imm) with funct3 not 001/101 decode as I: sext(inst[31:20]).
- Opcode 0010011 with funct3 001/101 decodes as SHAMT:
  - XLEN=32: zext(inst[24:20]).
  - XLEN=64: zext(inst[25:20]).
- 0100011 decodes as S: sext({inst[31:25], inst[11:7]}).
- 1100011 decodes as B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
- 0110111 / 0010111 decode as U: sext({inst[31:12], 12'b0}).
- 1101111 decodes as J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- Any other opcode: imm=0, fmt=NONE, illegal=1. The entry is still enqueued.
- Sign extension replicates the format's MSB (inst[31]) to bit XLEN-1.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != DEPTH) && !rst. There is no bypass: when full, in_ready stays 0 even while a pop occurs.
- out_valid = (count != 0).
- When empty, out_imm, out_fmt and out_illegal are forced to 0.
- Latency: an instruction pushed at edge N is visible at the head after edge N (one cycle) when the FIFO was empty.
- Simultaneous push and pop (non-full, non-empty): count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- flush is identical to rst for the FIFO state. A push in the same cycle as flush is dropped, and so is a pop.
- Head data stays stable while out_valid && !out_ready.
- in_valid with inst changing while in_ready=0 has no effect.

Test Plan:
- Reset, then push 0xFFC12083 (lw x1,-4(x2)) -> next cycle: out_valid=1, out_imm=0xFFFFFFFC, out_fmt=1, out_illegal=0, count=1.
- Stream the following with out_ready=1, XLEN=32 -> heads appear in order, one per cycle, with count held at 1:
  - 0x00512423 (sw) -> imm 0x00000008, fmt 2.
  - 0xFE000CE3 (beq -8) -> imm 0xFFFFFFF8, fmt 3.
  - 0x123450B7 (lui) -> imm 0x12345000, fmt 4.
  - 0x001000EF (jal +2048) -> imm 0x00000800, fmt 5.
- 0x01F0D093 (srli x1,x1,31) -> imm 0x1F, fmt 6. 0x0000007F -> imm 0, fmt 0, illegal 1.
- Hold out_ready=0 and push DEPTH=2 instructions -> count=2, in_ready=0. A third offer is ignored. Pulse out_ready for one cycle -> count=1 and in_ready=1 the following cycle. Head data is unchanged while stalled.
- Fill the FIFO, then assert flush together with in_valid=1 -> next cycle: count=0, out_valid=0, out_imm=0, and the flushed-cycle instruction is absent.
- With XLEN=64, push 0xFE000CE3 -> out_imm=0xFFFFFFFFFFFFFFF8. Push 0x03F0D093 (srli shamt 63) -> out_imm=0x3F, fmt 6.
- Push 4·DEPTH+1 instructions with random out_ready -> outputs match the input order exactly and pointers wrap correctly. Assert rst mid-stream -> all outputs 0 on the next cycle.
